// File: rtl/register_file.sv
// DEPTH x DATA_W register file with a shared address, a registered read port and a write port.
// Reset clears only the read register; the storage array keeps its contents.
module register_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADDr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wr_DATA,
  output logic [DATA_W-1:0] rd_DATA
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so preloaded contents survive. Writes are gated by rst,
  // so nothing is written while the block is held in reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem[ADDr] <= wr_DATA;
    end
  end

  // Non-blocking update of mem gives read-before-write at the same address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_DATA <= '0;
    end else if (rd_en) begin
      rd_DATA <= mem[ADDr];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed and scoreboard-checked bench for register_file.
module tb_register_file;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] ADDr;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_DATA;
  logic [DATA_W-1:0] rd_DATA;

  int unsigned nvec;
  int unsigned nerr;
  logic [DATA_W-1:0] model [DEPTH];

  register_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) DUT (
    .clk    (clk),
    .rst    (rst),
    .ADDr   (ADDr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_DATA(wr_DATA),
    .rd_DATA(rd_DATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nvec    = 0;
    nerr    = 0;
    rst     = 1'b1;
    ADDr    = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_DATA = '0;
    for (int k = 0; k < DEPTH; k++) begin
      DUT.mem[k] = 16'(k + 1);
      model[k]   = 16'(k + 1);
    end
    #2 rst = 1'b0;
    #1 chk("reset_async", rd_DATA, 16'h0000);

    // Write and read attempted during reset must be ignored.
    wr_en = 1'b1; rd_en = 1'b1; ADDr = 3'd7; wr_DATA = 16'hFFFF;
    tick();
    chk("reset_read_ignored", rd_DATA, 16'h0000);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;

    // Preload and read.
    rd_en = 1'b1; ADDr = 3'd5;
    tick();
    chk("preload_rd5", rd_DATA, 16'h0006);
    ADDr = 3'd7;
    tick();
    chk("reset_write_ignored_rd7", rd_DATA, 16'h0008);
    ADDr = 3'd0;
    tick();
    chk("preload_rd0", rd_DATA, 16'h0001);

    // Write then read.
    rd_en = 1'b0; wr_en = 1'b1; ADDr = 3'd3; wr_DATA = 16'hA5A5;
    tick();
    chk("hold_during_write", rd_DATA, 16'h0001);
    wr_en = 1'b0; rd_en = 1'b1; wr_DATA = 16'h5A5A;
    tick();
    chk("write_then_read3", rd_DATA, 16'hA5A5);

    // Read hold for three edges.
    rd_en = 1'b0; ADDr = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("read_hold", rd_DATA, 16'hA5A5);
    end

    // Read-before-write.
    wr_en = 1'b1; ADDr = 3'd2; wr_DATA = 16'h0011;
    tick();
    rd_en = 1'b1; wr_DATA = 16'h0022;
    tick();
    chk("rbw_old_value", rd_DATA, 16'h0011);
    wr_en = 1'b0;
    tick();
    chk("rbw_new_value", rd_DATA, 16'h0022);

    // Async reset between edges, then retention.
    ADDr = 3'd3;
    #2 rst = 1'b0;
    #1 chk("mid_reset_async", rd_DATA, 16'h0000);
    tick();
    chk("mid_reset_held", rd_DATA, 16'h0000);
    rst = 1'b1;
    tick();
    chk("retained_rd3", rd_DATA, 16'hA5A5);
    ADDr = 3'd2;
    tick();
    chk("retained_rd2", rd_DATA, 16'h0022);

    model[2] = 16'h0022;
    model[3] = 16'hA5A5;

    // Random sweep against the scoreboard.
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ADDr    = 3'($urandom_range(DEPTH - 1));
      wr_DATA = 16'($urandom);
      model[ADDr] = wr_DATA;
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 700; i++) begin
      logic [ADDR_W-1:0] a;
      a       = 3'($urandom_range(DEPTH - 1));
      ADDr    = a;
      wr_DATA = 16'($urandom);
      tick();
      chk("sweep_read", rd_DATA, model[a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
